// File: rtl/pulse_meter_pkg.sv
// Shared types and constants for the pulse_meter receive-side measurement block.
package pulse_meter_pkg;

  localparam int CNT_W = 32;

  // Default number of cycles without a rising edge before a measurement is abandoned.
  localparam logic [CNT_W-1:0] TIMEOUT_DEFAULT = 32'h05f5_e100;

  typedef enum logic [1:0] {
    ARM,
    IDLE,
    HIGH,
    LOW
  } state_t;

endpackage

// File: rtl/pulse_meter_sync.sv
// Synchronizer for the asynchronous pulse input: a SYNC_STAGES-deep flop chain.
module pulse_meter_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_d,
  output logic o_s
);

  logic [SYNC_STAGES-1:0] r_sync;

  // Shift the raw input through the chain; cleared by reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_s = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pulse_meter.sv
// Measures high time and rise-to-rise period of a pulse train in clock cycles,
// strobing valid per complete period and timeout when the line stops toggling.
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int               SYNC_STAGES = 2,
  parameter logic [CNT_W-1:0] TIMEOUT     = TIMEOUT_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] width,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             timeout,
  output logic             active
);

  localparam logic [CNT_W-1:0] ONE    = 1;
  localparam logic [CNT_W-1:0] SS_CNT = SYNC_STAGES;

  logic             w_s;
  logic             r_s_d;
  logic             w_rise;
  logic             w_fall;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_wcnt;
  logic [CNT_W-1:0] w_wcnt_nxt;
  logic [CNT_W-1:0] r_whold;
  logic [CNT_W-1:0] w_whold_nxt;
  logic             w_valid_nxt;
  logic             w_to_nxt;

  logic [CNT_W-1:0] r_width;
  logic [CNT_W-1:0] r_period;
  logic             r_valid;
  logic             r_timeout;
  logic             r_active;

  pulse_meter_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clock(clock),
    .i_reset(reset),
    .i_d    (pulse_in),
    .o_s    (w_s)
  );

  // Delayed copy of the synchronized line for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s_d <= 1'b0;
    end else begin
      r_s_d <= w_s;
    end
  end

  assign w_rise = w_s & ~r_s_d;
  assign w_fall = ~w_s & r_s_d;

  // Next-state, counter and strobe decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wcnt_nxt  = r_wcnt;
    w_whold_nxt = r_whold;
    w_valid_nxt = 1'b0;
    w_to_nxt    = 1'b0;
    unique case (r_state)
      ARM: begin
        // Let the synchronizer refill, then wait for the line to be low.
        if (r_cnt < SS_CNT) begin
          w_cnt_nxt = r_cnt + ONE;
        end else if (!w_s) begin
          w_state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = HIGH;
          w_cnt_nxt   = ONE;
          w_wcnt_nxt  = ONE;
        end
      end
      HIGH: begin
        // Timeout takes priority over a coincident fall.
        if (r_cnt == TIMEOUT) begin
          w_state_nxt = ARM;
          w_cnt_nxt   = '0;
          w_to_nxt    = 1'b1;
        end else begin
          w_cnt_nxt  = r_cnt + ONE;
          w_wcnt_nxt = r_wcnt + ONE;
          if (w_fall) begin
            w_whold_nxt = r_wcnt;
            w_state_nxt = LOW;
          end
        end
      end
      LOW: begin
        // A rise on the timeout cycle still completes the measurement.
        if (w_rise) begin
          w_valid_nxt = 1'b1;
          w_state_nxt = HIGH;
          w_cnt_nxt   = ONE;
          w_wcnt_nxt  = ONE;
        end else if (r_cnt == TIMEOUT) begin
          w_state_nxt = ARM;
          w_cnt_nxt   = '0;
          w_to_nxt    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + ONE;
        end
      end
      default: begin
        w_state_nxt = ARM;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ARM;
      r_cnt   <= '0;
      r_wcnt  <= '0;
      r_whold <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_whold <= w_whold_nxt;
    end
  end

  // Output registers: results hold until the next completed period.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_width   <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_active  <= 1'b0;
    end else begin
      r_valid   <= w_valid_nxt;
      r_timeout <= w_to_nxt;
      r_active  <= (w_state_nxt == HIGH) || (w_state_nxt == LOW);
      if (w_valid_nxt) begin
        r_width  <= r_whold;
        r_period <= r_cnt;
      end
    end
  end

  assign width   = r_width;
  assign period  = r_period;
  assign valid   = r_valid;
  assign timeout = r_timeout;
  assign active  = r_active;

endmodule

// File: tb/tb_pulse_meter.sv
// Self-checking bench for pulse_meter. Four instances share the stimulus:
// index 0..2 use SYNC_STAGES 2..4 with the default timeout, index 3 uses
// SYNC_STAGES 3 with TIMEOUT 20. A monitor logs strobes of the selected one.
module tb_pulse_meter;

  logic clock    = 1'b0;
  logic reset    = 1'b1;
  logic pulse_in = 1'b0;

  logic [31:0] dw [4];
  logic [31:0] dp [4];
  logic        dv [4];
  logic        dt [4];
  logic        da [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    pulse_meter #(
      .SYNC_STAGES((g < 3) ? g + 2 : 3),
      .TIMEOUT    ((g < 3) ? 32'h05f5_e100 : 32'd20)
    ) u_dut (
      .clock   (clock),
      .reset   (reset),
      .pulse_in(pulse_in),
      .width   (dw[g]),
      .period  (dp[g]),
      .valid   (dv[g]),
      .timeout (dt[g]),
      .active  (da[g])
    );
  end

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int sel    = 0;
  int both   = 0;

  typedef struct {
    int          cyc;
    logic [31:0] w;
    logic [31:0] p;
  } ev_t;

  ev_t vq [$];
  int  tq [$];
  int  rq [$];

  // Strobe log for the selected instance, sampled just after each edge.
  always @(posedge clock) begin
    #1;
    if (dv[sel]) vq.push_back('{cyc, dw[sel], dp[sel]});
    if (dt[sel]) tq.push_back(cyc);
    if (dv[sel] && dt[sel]) both++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ss_of(input int d);
    return (d < 3) ? d + 2 : 3;
  endfunction

  task automatic drive(input logic v);
    @(negedge clock);
    if (v && !pulse_in) rq.push_back(cyc);
    pulse_in = v;
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) drive(v);
  endtask

  task automatic train(input int h, input int l, input int n);
    for (int k = 0; k < n; k++) begin
      hold(1'b1, h);
      hold(1'b0, l);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic clear_log();
    vq.delete();
    tq.delete();
    rq.delete();
    both = 0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    for (int g = 0; g < 4; g++) begin
      checks++;
      if ({dw[g], dp[g], dv[g], dt[g], da[g]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got w=%0d p=%0d v=%b t=%b a=%b expected all 0",
                 g, dw[g], dp[g], dv[g], dt[g], da[g]);
      end
    end
    reset = 1'b0;
    hold(1'b0, 8);
    checks++;
    if (da[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_active: got %b expected 0", da[0]);
    end
  endtask

  // Constant trains on one instance: every period after the first is reported.
  task automatic test_train(input string name, input int d, input int h, input int l, input int n);
    int ss;
    ss  = ss_of(d);
    sel = d;
    do_reset();
    hold(1'b0, 8);
    clear_log();
    train(h, l, n);
    hold(1'b1, 6);
    checks++;
    if (vq.size() != n) begin
      errors++;
      $display("FAIL %s_count: got %0d valids expected %0d", name, vq.size(), n);
    end
    for (int k = 1; k <= n; k++) begin
      if (k - 1 < vq.size() && k < rq.size()) begin
        checks++;
        if (vq[k-1].cyc != rq[k] + ss + 1 || vq[k-1].w !== 32'(h) || vq[k-1].p !== 32'(h + l)) begin
          errors++;
          $display("FAIL %s_valid[%0d]: got cyc=%0d w=%0d p=%0d expected cyc=%0d w=%0d p=%0d",
                   name, k, vq[k-1].cyc, vq[k-1].w, vq[k-1].p, rq[k] + ss + 1, h, h + l);
        end
      end
    end
    checks++;
    if (tq.size() != 0 || both != 0) begin
      errors++;
      $display("FAIL %s_no_timeout: got %0d timeouts, %0d overlaps expected 0", name, tq.size(), both);
    end
  endtask

  // TIMEOUT=20: 5/15 reports period 20; 5/16 times out and keeps the last result.
  task automatic test_timeout_boundary();
    sel = 3;
    do_reset();
    hold(1'b0, 8);
    clear_log();
    train(5, 15, 3);
    train(5, 16, 3);
    hold(1'b0, 10);
    checks++;
    if (vq.size() != 3) begin
      errors++;
      $display("FAIL tob_valid_count: got %0d expected 3", vq.size());
    end
    for (int k = 1; k <= 3; k++) begin
      if (k - 1 < vq.size()) begin
        checks++;
        if (vq[k-1].cyc != rq[k] + 4 || vq[k-1].w !== 32'd5 || vq[k-1].p !== 32'd20) begin
          errors++;
          $display("FAIL tob_valid[%0d]: got cyc=%0d w=%0d p=%0d expected cyc=%0d w=5 p=20",
                   k, vq[k-1].cyc, vq[k-1].w, vq[k-1].p, rq[k] + 4);
        end
      end
    end
    checks++;
    if (tq.size() != 2) begin
      errors++;
      $display("FAIL tob_timeout_count: got %0d expected 2", tq.size());
    end else begin
      checks++;
      if (tq[0] != rq[3] + 24 || tq[1] != rq[5] + 24) begin
        errors++;
        $display("FAIL tob_timeout_cyc: got %0d,%0d expected %0d,%0d", tq[0], tq[1], rq[3] + 24, rq[5] + 24);
      end
    end
    checks++;
    if (dw[3] !== 32'd5 || dp[3] !== 32'd20 || da[3] !== 1'b0 || both != 0) begin
      errors++;
      $display("FAIL tob_hold: got w=%0d p=%0d a=%b overlaps=%0d expected w=5 p=20 a=0 overlaps=0",
               dw[3], dp[3], da[3], both);
    end
  endtask

  // TIMEOUT=20: line stuck high gives one timeout, then a 4/6 train recovers.
  task automatic test_stuck_high();
    sel = 3;
    do_reset();
    hold(1'b0, 8);
    clear_log();
    hold(1'b1, 40);
    hold(1'b0, 6);
    train(4, 6, 2);
    hold(1'b1, 6);
    checks++;
    if (tq.size() != 1) begin
      errors++;
      $display("FAIL stuck_timeout_count: got %0d expected 1", tq.size());
    end else begin
      checks++;
      if (tq[0] != rq[0] + 24) begin
        errors++;
        $display("FAIL stuck_timeout_cyc: got %0d expected %0d", tq[0], rq[0] + 24);
      end
    end
    checks++;
    if (vq.size() != 2) begin
      errors++;
      $display("FAIL stuck_valid_count: got %0d expected 2", vq.size());
    end
    for (int k = 2; k <= 3; k++) begin
      if (k - 2 < vq.size()) begin
        checks++;
        if (vq[k-2].cyc != rq[k] + 4 || vq[k-2].w !== 32'd4 || vq[k-2].p !== 32'd10) begin
          errors++;
          $display("FAIL stuck_valid[%0d]: got cyc=%0d w=%0d p=%0d expected cyc=%0d w=4 p=10",
                   k, vq[k-2].cyc, vq[k-2].w, vq[k-2].p, rq[k] + 4);
        end
      end
    end
  endtask

  // Reset in the middle of a high phase with the line held high through release.
  task automatic test_reset_mid_high();
    sel = 0;
    do_reset();
    hold(1'b0, 8);
    train(3, 7, 2);
    hold(1'b1, 5);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    for (int g = 0; g < 4; g++) begin
      checks++;
      if ({dw[g], dp[g], dv[g], dt[g], da[g]} !== '0) begin
        errors++;
        $display("FAIL midreset_outputs[%0d]: got w=%0d p=%0d v=%b t=%b a=%b expected all 0",
                 g, dw[g], dp[g], dv[g], dt[g], da[g]);
      end
    end
    reset = 1'b0;
    clear_log();
    hold(1'b1, 10);
    checks++;
    if (da[0] !== 1'b0 || vq.size() != 0 || tq.size() != 0) begin
      errors++;
      $display("FAIL midreset_hold_high: got a=%b valids=%0d timeouts=%0d expected 0,0,0",
               da[0], vq.size(), tq.size());
    end
    hold(1'b0, 5);
    train(3, 7, 2);
    hold(1'b1, 6);
    checks++;
    if (vq.size() != 2 || tq.size() != 0) begin
      errors++;
      $display("FAIL midreset_count: got %0d valids %0d timeouts expected 2 and 0", vq.size(), tq.size());
    end
    for (int k = 1; k <= 2; k++) begin
      if (k - 1 < vq.size()) begin
        checks++;
        if (vq[k-1].cyc != rq[k] + 3 || vq[k-1].w !== 32'd3 || vq[k-1].p !== 32'd10) begin
          errors++;
          $display("FAIL midreset_valid[%0d]: got cyc=%0d w=%0d p=%0d expected cyc=%0d w=3 p=10",
                   k, vq[k-1].cyc, vq[k-1].w, vq[k-1].p, rq[k] + 3);
        end
      end
    end
  endtask

  // Random H/L per period; expected cycle, width and period from running sums.
  task automatic test_random();
    int hs [$];
    int ls [$];
    int ss;
    int t;
    int h;
    int l;
    for (int it = 0; it < 4; it++) begin
      sel = int'($urandom_range(0, 2));
      ss  = ss_of(sel);
      do_reset();
      hold(1'b0, 8);
      clear_log();
      hs.delete();
      ls.delete();
      for (int k = 0; k < 12; k++) begin
        h = int'($urandom_range(1, 50));
        l = int'($urandom_range(1, 50));
        hs.push_back(h);
        ls.push_back(l);
        hold(1'b1, h);
        hold(1'b0, l);
      end
      hold(1'b1, 6);
      checks++;
      if (vq.size() != 12 || tq.size() != 0 || both != 0) begin
        errors++;
        $display("FAIL rand_count[%0d]: got %0d valids %0d timeouts expected 12 and 0", it, vq.size(), tq.size());
      end
      if (rq.size() > 0) begin
        t = rq[0];
        for (int k = 0; k < 12; k++) begin
          t = t + hs[k] + ls[k];
          if (k < vq.size()) begin
            checks++;
            if (vq[k].cyc != t + ss + 1 || vq[k].w !== 32'(hs[k]) || vq[k].p !== 32'(hs[k] + ls[k])) begin
              errors++;
              $display("FAIL rand_valid[%0d.%0d] ss=%0d: got cyc=%0d w=%0d p=%0d expected cyc=%0d w=%0d p=%0d",
                       it, k, ss, vq[k].cyc, vq[k].w, vq[k].p, t + ss + 1, hs[k], hs[k] + ls[k]);
            end
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_train("basic", 0, 3, 7, 5);
    test_train("min0", 0, 1, 1, 8);
    test_train("min2", 2, 1, 1, 8);
    test_timeout_boundary();
    test_stuck_high();
    test_reset_mid_high();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
